// File: rtl/fcore_instruction_decoder.sv
// fcore_instruction_decoder: single-stage instruction decoder with LDC constant
// capture, STOP/run control and valid/ready handshakes on both sides.
// Optional feature macro: FCORE_ILLEGAL_TRAP_EN -- an illegal opcode sets a sticky
// illegal_op flag and halts; without it illegal opcodes are forwarded as NOP.
module fcore_instruction_decoder #(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int OPCODE_WIDTH      = 5,
    parameter int REG_ADDR_WIDTH    = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         run,
    input  logic [INSTRUCTION_WIDTH-1:0] instr_in,
    input  logic                         instr_valid,
    output logic                         instr_ready,
    output logic [OPCODE_WIDTH-1:0]      opcode_out,
    output logic [REG_ADDR_WIDTH-1:0]    op_a,
    output logic [REG_ADDR_WIDTH-1:0]    op_b,
    output logic [REG_ADDR_WIDTH-1:0]    dest,
    output logic [INSTRUCTION_WIDTH-1:0] immediate,
    output logic                         exe_valid,
    input  logic                         exe_ready,
    output logic                         is_branch,
    output logic                         efi_start,
    output logic                         done,
    output logic                         illegal_op
);
    localparam int OPA_LSB  = OPCODE_WIDTH;
    localparam int OPB_LSB  = OPA_LSB + REG_ADDR_WIDTH;
    localparam int DEST_LSB = OPB_LSB + REG_ADDR_WIDTH;

    localparam logic [OPCODE_WIDTH-1:0] OP_LDC  = OPCODE_WIDTH'(6);
    localparam logic [OPCODE_WIDTH-1:0] OP_BGT  = OPCODE_WIDTH'(8);
    localparam logic [OPCODE_WIDTH-1:0] OP_BNE  = OPCODE_WIDTH'(11);
    localparam logic [OPCODE_WIDTH-1:0] OP_STOP = OPCODE_WIDTH'(12);
    localparam logic [OPCODE_WIDTH-1:0] OP_EFI  = OPCODE_WIDTH'(21);

    typedef enum logic [1:0] {DECODE, LDC_CONST, STOPPED} state_t;

    state_t                      state, state_nxt;
    logic [OPCODE_WIDTH-1:0]     f_opcode;
    logic [REG_ADDR_WIDTH-1:0]   f_op_a, f_op_b, f_dest;
    logic [REG_ADDR_WIDTH-1:0]   ldc_dest;
    logic                        accept, f_illegal, trap;
    logic                        load_insn, load_const, load_ldc_dest, stop_hit;

    assign f_opcode  = instr_in[OPCODE_WIDTH-1:0];
    assign f_op_a    = instr_in[OPA_LSB +: REG_ADDR_WIDTH];
    assign f_op_b    = instr_in[OPB_LSB +: REG_ADDR_WIDTH];
    assign f_dest    = instr_in[DEST_LSB +: REG_ADDR_WIDTH];
    assign f_illegal = (f_opcode > OP_EFI);

    // A new word may enter only when the output slot is empty or draining this cycle.
    assign instr_ready = (state != STOPPED) && (!exe_valid || exe_ready);
    assign accept      = instr_valid && instr_ready;

`ifdef FCORE_ILLEGAL_TRAP_EN
    assign trap = f_illegal;
`else
    assign trap = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= DECODE;
        else        state <= state_nxt;
    end

    // Next state and per-word load controls.
    always_comb begin
        state_nxt     = state;
        load_insn     = 1'b0;
        load_const    = 1'b0;
        load_ldc_dest = 1'b0;
        stop_hit      = 1'b0;
        case (state)
            DECODE: begin
                if (accept) begin
                    if (trap) begin
                        state_nxt = STOPPED;
                    end else if (f_opcode == OP_LDC) begin
                        load_ldc_dest = 1'b1;
                        state_nxt     = LDC_CONST;
                    end else begin
                        load_insn = 1'b1;
                        if (f_opcode == OP_STOP) begin
                            stop_hit  = 1'b1;
                            state_nxt = STOPPED;
                        end
                    end
                end
            end
            LDC_CONST: begin
                // The constant word is taken verbatim, never decoded.
                if (accept) begin
                    load_const = 1'b1;
                    state_nxt  = DECODE;
                end
            end
            STOPPED: begin
                if (run) state_nxt = DECODE;
            end
            default: state_nxt = DECODE;
        endcase
    end

    // Output register: loads on a decoded word or LDC constant, holds while stalled.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            exe_valid  <= 1'b0;
            done       <= 1'b0;
            opcode_out <= '0;
            op_a       <= '0;
            op_b       <= '0;
            dest       <= '0;
            immediate  <= '0;
            is_branch  <= 1'b0;
            efi_start  <= 1'b0;
            ldc_dest   <= '0;
        end else begin
            done <= stop_hit;
            if (load_insn) begin
                // Illegal opcodes reaching here are forwarded as a clean NOP.
                exe_valid  <= 1'b1;
                opcode_out <= f_illegal ? '0 : f_opcode;
                op_a       <= f_illegal ? '0 : f_op_a;
                op_b       <= f_illegal ? '0 : f_op_b;
                dest       <= f_illegal ? '0 : f_dest;
                immediate  <= '0;
                is_branch  <= (f_opcode >= OP_BGT) && (f_opcode <= OP_BNE);
                efi_start  <= (f_opcode == OP_EFI);
            end else if (load_const) begin
                exe_valid  <= 1'b1;
                opcode_out <= OP_LDC;
                op_a       <= '0;
                op_b       <= '0;
                dest       <= ldc_dest;
                immediate  <= instr_in;
                is_branch  <= 1'b0;
                efi_start  <= 1'b0;
            end else if (exe_ready) begin
                exe_valid <= 1'b0;
            end
            if (load_ldc_dest) ldc_dest <= f_dest;
        end
    end

`ifdef FCORE_ILLEGAL_TRAP_EN
    // Sticky trap flag; only reset clears it, run does not.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                                 illegal_op <= 1'b0;
        else if (accept && state == DECODE && trap) illegal_op <= 1'b1;
    end
`else
    assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_fcore_instruction_decoder.sv
// Bench for fcore_instruction_decoder: directed scenarios plus a randomized
// program stream checked against a transaction-level reference queue.
module tb_fcore_instruction_decoder;
    logic        clock = 1'b0;
    logic        reset, run, instr_valid, instr_ready, exe_valid, exe_ready;
    logic [31:0] instr_in, immediate;
    logic [4:0]  opcode_out;
    logic [7:0]  op_a, op_b, dest;
    logic        is_branch, efi_start, done, illegal_op;

    int total  = 0;
    int passed = 0;

    fcore_instruction_decoder dut (
        .clock(clock), .reset(reset), .run(run), .instr_in(instr_in),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .opcode_out(opcode_out),
        .op_a(op_a), .op_b(op_b), .dest(dest), .immediate(immediate),
        .exe_valid(exe_valid), .exe_ready(exe_ready), .is_branch(is_branch),
        .efi_start(efi_start), .done(done), .illegal_op(illegal_op)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  opc;
        logic [7:0]  a, b, d;
        logic [31:0] imm;
        logic        br, efi;
        bit          chk_ab, chk_d, chk_imm;
    } exp_t;

    function automatic logic [31:0] mk(int opc, int a, int b, int d);
        return {3'b000, 8'(d), 8'(b), 8'(a), 5'(opc)};
    endfunction

    function automatic logic [63:0] out_vec();
        return {exe_valid, opcode_out, op_a, op_b, dest, immediate, is_branch, efi_start};
    endfunction

    task automatic do_reset();
        @(negedge clock);
        run = 0; instr_valid = 0; instr_in = 0; exe_ready = 0;
        reset = 0;
        @(negedge clock);
        reset = 1;
    endtask

    task automatic test_reset();
        run = 0; instr_valid = 0; instr_in = 0; exe_ready = 0; reset = 0;
        #12;
        total++; if (out_vec() !== 64'h0) $display("FAIL reset_outputs: got %h exp 0", out_vec()); else passed++;
        total++; if ({done, illegal_op} !== 2'b00) $display("FAIL reset_flags: got %b exp 00", {done, illegal_op}); else passed++;
        @(negedge clock); reset = 1;
        repeat (3) @(negedge clock);
        total++; if (out_vec() !== 64'h0) $display("FAIL idle_after_reset: got %h exp 0", out_vec()); else passed++;
        total++; if (instr_ready !== 1'b1) $display("FAIL ready_after_reset: got %b exp 1", instr_ready); else passed++;
    endtask

    task automatic test_add();
        do_reset();
        exe_ready = 1; instr_in = mk(1, 1, 2, 3); instr_valid = 1;
        @(negedge clock); instr_valid = 0;
        total++;
        if ({exe_valid, opcode_out, op_a, op_b, dest} !== {1'b1, 5'd1, 8'd1, 8'd2, 8'd3})
            $display("FAIL add_decode: got v=%b opc=%0d a=%0d b=%0d d=%0d exp v=1 opc=1 a=1 b=2 d=3",
                     exe_valid, opcode_out, op_a, op_b, dest);
        else passed++;
        @(negedge clock);
        total++; if (exe_valid !== 1'b0) $display("FAIL add_valid_clear: got %b exp 0", exe_valid); else passed++;
        // run outside STOPPED has no effect
        run = 1; @(negedge clock); run = 0;
        total++; if (instr_ready !== 1'b1 || exe_valid !== 1'b0) $display("FAIL run_ignored: got rdy=%b v=%b exp rdy=1 v=0", instr_ready, exe_valid); else passed++;
    endtask

    task automatic test_ldc();
        int pulses;
        do_reset();
        exe_ready = 1; instr_in = mk(6, 0, 0, 5); instr_valid = 1;
        @(negedge clock); instr_in = 32'h3F80_0000;
        total++; if (exe_valid !== 1'b0) $display("FAIL ldc_first_word_valid: got %b exp 0", exe_valid); else passed++;
        @(negedge clock); instr_valid = 0;
        total++;
        if ({exe_valid, opcode_out, dest, immediate} !== {1'b1, 5'd6, 8'd5, 32'h3F80_0000})
            $display("FAIL ldc_const: got v=%b opc=%0d d=%0d imm=%h exp v=1 opc=6 d=5 imm=3f800000",
                     exe_valid, opcode_out, dest, immediate);
        else passed++;
        pulses = 0;
        repeat (4) begin @(negedge clock); if (exe_valid) pulses++; end
        total++; if (pulses !== 0) $display("FAIL ldc_single_pulse: got %0d extra pulses exp 0", pulses); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [3];
        do_reset();
        for (int i = 0; i < 3; i++) w[i] = mk(2, $urandom_range(0, 255), $urandom_range(0, 255), i + 1);
        exe_ready = 0; instr_in = w[0]; instr_valid = 1;
        @(negedge clock); instr_in = w[1];
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (instr_ready !== 1'b0) $display("FAIL b2b_stall_ready[%0d]: got %b exp 0", i, instr_ready); else passed++;
            total++;
            if ({exe_valid, opcode_out, op_a, op_b, dest} !== {1'b1, w[0][4:0], w[0][12:5], w[0][20:13], w[0][28:21]})
                $display("FAIL b2b_stall_hold[%0d]: got v=%b opc=%0d d=%0d exp v=1 opc=2 d=1", i, exe_valid, opcode_out, dest);
            else passed++;
            @(negedge clock);
        end
        exe_ready = 1;
        for (int i = 1; i < 3; i++) begin
            @(negedge clock);
            if (i == 1) instr_in = w[2]; else instr_valid = 0;
            total++;
            if ({exe_valid, opcode_out, op_a, op_b, dest} !== {1'b1, w[i][4:0], w[i][12:5], w[i][20:13], w[i][28:21]})
                $display("FAIL b2b_deliver[%0d]: got v=%b opc=%0d a=%0d b=%0d d=%0d exp d=%0d",
                         i, exe_valid, opcode_out, op_a, op_b, dest, i + 1);
            else passed++;
        end
        @(negedge clock);
        total++; if (exe_valid !== 1'b0) $display("FAIL b2b_drain: got %b exp 0", exe_valid); else passed++;
    endtask

    task automatic test_stop();
        int done_cnt;
        do_reset();
        exe_ready = 1; instr_in = mk(12, 0, 0, 0); instr_valid = 1;
        @(negedge clock); instr_in = mk(1, 7, 8, 9);
        total++;
        if ({exe_valid, opcode_out, done} !== {1'b1, 5'd12, 1'b1})
            $display("FAIL stop_present: got v=%b opc=%0d done=%b exp v=1 opc=12 done=1", exe_valid, opcode_out, done);
        else passed++;
        done_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); #1;
            if (done) done_cnt++;
            total++; if (instr_ready !== 1'b0) $display("FAIL stop_ready_low[%0d]: got %b exp 0", i, instr_ready); else passed++;
        end
        total++; if (done_cnt !== 0 || exe_valid !== 1'b0) $display("FAIL stop_done_once: got extra=%0d v=%b exp 0 0", done_cnt, exe_valid); else passed++;
        run = 1;
        @(negedge clock); run = 0;
        total++; if (instr_ready !== 1'b1) $display("FAIL run_resume: got %b exp 1", instr_ready); else passed++;
        @(negedge clock); instr_valid = 0;
        total++;
        if ({exe_valid, opcode_out, op_a, op_b, dest, done} !== {1'b1, 5'd1, 8'd7, 8'd8, 8'd9, 1'b0})
            $display("FAIL stop_then_add: got v=%b opc=%0d a=%0d b=%0d d=%0d done=%b exp v=1 opc=1 a=7 b=8 d=9 done=0",
                     exe_valid, opcode_out, op_a, op_b, dest, done);
        else passed++;
    endtask

    task automatic test_illegal();
        do_reset();
        exe_ready = 1; instr_in = mk(25, 4, 5, 6); instr_valid = 1;
        @(negedge clock); instr_valid = 0;
`ifdef FCORE_ILLEGAL_TRAP_EN
        #1;
        total++;
        if ({illegal_op, exe_valid, done, instr_ready} !== 4'b1000)
            $display("FAIL illegal_trap: got ill=%b v=%b done=%b rdy=%b exp 1 0 0 0", illegal_op, exe_valid, done, instr_ready);
        else passed++;
        run = 1; @(negedge clock); run = 0;
        total++;
        if ({illegal_op, instr_ready} !== 2'b11)
            $display("FAIL illegal_sticky: got ill=%b rdy=%b exp 1 1", illegal_op, instr_ready);
        else passed++;
`else
        total++;
        if ({exe_valid, opcode_out, illegal_op} !== {1'b1, 5'd0, 1'b0})
            $display("FAIL illegal_as_nop: got v=%b opc=%0d ill=%b exp v=1 opc=0 ill=0", exe_valid, opcode_out, illegal_op);
        else passed++;
`endif
    endtask

    task automatic test_reset_mid_ldc();
        do_reset();
        exe_ready = 1; instr_in = mk(6, 0, 0, 9); instr_valid = 1;
        @(negedge clock); instr_valid = 0;
        #2 reset = 0;
        #2;
        total++; if (out_vec() !== 64'h0) $display("FAIL mid_ldc_reset: got %h exp 0", out_vec()); else passed++;
        @(negedge clock); reset = 1; instr_in = 32'h0000_0001; instr_valid = 1;
        @(negedge clock); instr_valid = 0;
        total++;
        if ({exe_valid, opcode_out, dest, immediate} !== {1'b1, 5'd1, 8'd0, 32'h0})
            $display("FAIL mid_ldc_first_word: got v=%b opc=%0d d=%0d imm=%h exp v=1 opc=1 d=0 imm=0",
                     exe_valid, opcode_out, dest, immediate);
        else passed++;
    endtask

    task automatic test_random();
        logic [31:0] prog[$];
        exp_t        q[$];
        exp_t        e;
        logic [31:0] w;
        logic [63:0] snap;
        int          opc, idx, cyc, n;
        bit          stall_prev;
        do_reset();
        // Build the program and the expected transaction stream up front.
        for (int i = 0; i < 150; i++) begin
            do begin
                opc = $urandom_range(0, 31);
`ifdef FCORE_ILLEGAL_TRAP_EN
            end while (opc == 12 || opc > 21);
`else
            end while (opc == 12);
`endif
            w = $urandom();
            w[4:0] = 5'(opc);
            prog.push_back(w);
            if (opc == 6) begin
                e = '{opc: 5'd6, a: 8'd0, b: 8'd0, d: w[28:21], imm: $urandom(), br: 1'b0, efi: 1'b0,
                      chk_ab: 1'b0, chk_d: 1'b1, chk_imm: 1'b1};
                prog.push_back(e.imm);
            end else if (opc > 21) begin
                e = '{opc: 5'd0, a: 8'd0, b: 8'd0, d: 8'd0, imm: 32'd0, br: 1'b0, efi: 1'b0,
                      chk_ab: 1'b0, chk_d: 1'b0, chk_imm: 1'b0};
            end else begin
                e = '{opc: 5'(opc), a: w[12:5], b: w[20:13], d: w[28:21], imm: 32'd0,
                      br: (opc >= 8 && opc <= 11), efi: (opc == 21),
                      chk_ab: 1'b1, chk_d: 1'b1, chk_imm: 1'b0};
            end
            q.push_back(e);
        end
        idx = 0; cyc = 0; n = 0; stall_prev = 0; snap = '0;
        while ((idx < prog.size() || q.size() != 0) && cyc < 5000) begin
            @(negedge clock);
            cyc++;
            if (stall_prev) begin
                total++; if (out_vec() !== snap) $display("FAIL rand_stall_hold: got %h exp %h", out_vec(), snap); else passed++;
            end
            instr_valid = (idx < prog.size()) && ($urandom_range(0, 3) != 0);
            instr_in    = (idx < prog.size()) ? prog[idx] : $urandom();
            exe_ready   = ($urandom_range(0, 2) != 0);
            #1;
            total++;
            if (instr_ready !== (!exe_valid || exe_ready) || done !== 1'b0 || illegal_op !== 1'b0)
                $display("FAIL rand_ready_rule: got rdy=%b done=%b ill=%b exp rdy=%b done=0 ill=0",
                         instr_ready, done, illegal_op, (!exe_valid || exe_ready));
            else passed++;
            if (exe_valid && exe_ready) begin
                total++;
                if (q.size() == 0) begin
                    $display("FAIL rand_extra_txn: got opc=%0d exp none", opcode_out);
                end else begin
                    e = q.pop_front();
                    if (opcode_out !== e.opc || is_branch !== e.br || efi_start !== e.efi ||
                        (e.chk_ab && (op_a !== e.a || op_b !== e.b)) ||
                        (e.chk_d && dest !== e.d) || (e.chk_imm && immediate !== e.imm))
                        $display("FAIL rand_txn[%0d]: got opc=%0d a=%0d b=%0d d=%0d imm=%h br=%b efi=%b exp opc=%0d a=%0d b=%0d d=%0d imm=%h br=%b efi=%b",
                                 n, opcode_out, op_a, op_b, dest, immediate, is_branch, efi_start,
                                 e.opc, e.a, e.b, e.d, e.imm, e.br, e.efi);
                    else passed++;
                    n++;
                end
            end
            stall_prev = exe_valid && !exe_ready;
            snap       = out_vec();
            if (instr_valid && instr_ready) idx++;
        end
        instr_valid = 0;
        total++;
        if (cyc >= 5000 || q.size() != 0 || idx != prog.size())
            $display("FAIL rand_complete: got cyc=%0d left=%0d fed=%0d exp all %0d words delivered",
                     cyc, q.size(), idx, prog.size());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_ldc();
        test_back_to_back();
        test_stop();
        test_illegal();
        test_reset_mid_ldc();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fcore_instruction_decoder.md
FCORE_INSTRUCTION_DECODER -- requirements
Module: fcore_instruction_decoder

Interface
REQ-001 Parameters SHALL be: INSTRUCTION_WIDTH, default 32, instruction word width; OPCODE_WIDTH, default 5, opcode field width; REG_ADDR_WIDTH, default 8, register address field width.
REQ-002 Port clock, input, 1 bit, SHALL be the single clock; every flop is rising-edge.
REQ-003 Port reset, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-004 Port run, input, 1 bit, SHALL be a one-cycle pulse that releases the STOPPED state.
REQ-005 Port instr_in, input, INSTRUCTION_WIDTH bits, SHALL carry the program word; instr_valid (input, 1 bit) and instr_ready (output, 1 bit) SHALL form its valid/ready handshake.
REQ-006 Port opcode_out, output, OPCODE_WIDTH bits, SHALL carry the decoded opcode.
REQ-007 Ports op_a, op_b and dest, output, REG_ADDR_WIDTH bits each, SHALL carry the operand and destination addresses.
REQ-008 Port immediate, output, INSTRUCTION_WIDTH bits, SHALL carry the LDC constant.
REQ-009 Port exe_valid, output, 1 bit, and port exe_ready, input, 1 bit, SHALL form the downstream handshake.
REQ-010 Port is_branch, output, 1 bit, SHALL be high for BGT/BLE/BEQ/BNE.
REQ-011 Port efi_start, output, 1 bit, SHALL be high for EFI.
REQ-012 Port done, output, 1 bit, SHALL pulse for one cycle when STOP is decoded.
REQ-013 Port illegal_op, output, 1 bit, SHALL be the sticky illegal-opcode flag.

Function
REQ-014 Field layout SHALL be: opcode at [OPCODE_WIDTH-1:0]; op_a next above it; op_b above op_a; dest above op_b; remaining bits ignored.
REQ-015 Legal opcodes SHALL be 0..21 (NOP, ADD, SUB, MUL, ITF, FTI, LDC, LDR, BGT, BLE, BEQ, BNE, STOP, LAND, LOR, LNOT, SATP, SATN, REC, POPCNT, ABS, EFI); 22 and above are illegal.
REQ-016 The FSM SHALL have exactly three states: DECODE, LDC_CONST, STOPPED.
REQ-017 An accepted word is one with instr_valid && instr_ready at a rising edge.
REQ-018 instr_ready SHALL equal (state != STOPPED) && (!exe_valid || exe_ready).
REQ-019 In DECODE, an accepted non-LDC word SHALL register all output fields and assert exe_valid on the next cycle, giving 1-cycle latency.
REQ-020 In DECODE, an accepted LDC word SHALL latch dest, leave exe_valid low, and move to LDC_CONST.
REQ-021 In LDC_CONST, the next accepted word SHALL be loaded verbatim into immediate, raise exe_valid with opcode_out=LDC, and return to DECODE; the word SHALL never be decoded as an opcode.
REQ-022 When exe_valid is high and exe_ready is low, all outputs SHALL hold stable and no new word is accepted.
REQ-023 exe_valid SHALL clear on the cycle after a handshake unless a new word is accepted in that same cycle; a back-to-back accept SHALL sustain one word per cycle.
REQ-024 Accepting STOP SHALL present STOP on exe_valid like any other instruction, pulse done for one cycle, and move to STOPPED.
REQ-025 In STOPPED, instr_ready SHALL be 0; a run pulse SHALL return the FSM to DECODE on the next cycle.
REQ-026 run in any state other than STOPPED SHALL be ignored.
REQ-027 NOP SHALL be forwarded with exe_valid like other instructions.
REQ-028 is_branch and efi_start SHALL be registered alongside opcode_out and hold with it.

Reset
REQ-029 Asserting reset SHALL force state to DECODE and clear every output to 0: exe_valid, done, illegal_op, is_branch, efi_start, opcode_out, op_a, op_b, dest, immediate.
REQ-030 Reset asserted mid-LDC SHALL discard the pending dest; the first word after release SHALL be decoded as an opcode.
REQ-031 Outputs SHALL not change between reset release and the first accepted word.

Configuration
REQ-032 With macro FCORE_ILLEGAL_TRAP_EN defined, an accepted illegal opcode SHALL set illegal_op, suppress exe_valid for that word, and enter STOPPED without pulsing done.
REQ-033 With FCORE_ILLEGAL_TRAP_EN defined, illegal_op SHALL stay set until reset; run SHALL resume decoding but SHALL not clear illegal_op.
REQ-034 Without FCORE_ILLEGAL_TRAP_EN, an illegal opcode SHALL be forwarded as NOP (opcode_out=0, exe_valid=1), and illegal_op SHALL be tied to 0.

Verification
REQ-035 ADD word {dest=3, op_b=2, op_a=1, opcode=1} with exe_ready=1 -> next cycle exe_valid=1, opcode_out=1, op_a=1, op_b=2, dest=3.
REQ-036 LDC dest=5 followed by word 0x3F800000 -> exactly one exe_valid pulse, opcode_out=6, dest=5, immediate=0x3F800000; the constant word is never decoded as an opcode.
REQ-037 Three back-to-back SUB words with exe_ready low for 4 cycles -> outputs frozen on the first SUB, instr_ready=0; after release all three are delivered in order, one per cycle.
REQ-038 STOP followed by ADD held valid -> done pulses once, instr_ready=0 until run is pulsed, then ADD is decoded.
REQ-039 Opcode 25 -> with the macro: illegal_op=1, no exe_valid, FSM in STOPPED; without the macro: exe_valid=1, opcode_out=0.
REQ-040 Reset asserted in LDC_CONST, released, then word 0x00000001 -> decoded as ADD, immediate=0.
